// File: rtl/fetch_axi_read_arbiter.sv
// fetch_axi_read_arbiter
// Shares one AXI4 read master port between instruction fetch (source 0) and
// the data-side refill/uncached load path (source 1). AR requests are granted
// round-robin, registered, and tagged with the source in arid[3]. R beats are
// routed back combinationally by rid[3]. Per-source outstanding burst counts
// throttle each requester at MAX_OUTSTANDING.
module fetch_axi_read_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    // source 0 AR
    input  logic [3:0]    s0_arid,
    input  logic [31:0]   s0_araddr,
    input  logic [7:0]    s0_arlen,
    input  logic [2:0]    s0_arsize,
    input  logic [1:0]    s0_arburst,
    input  logic          s0_aruser,
    input  logic          s0_arvalid,
    output logic          s0_arready,
    // source 0 R
    output logic [3:0]    s0_rid,
    output logic [31:0]   s0_rdata,
    output logic [1:0]    s0_rresp,
    output logic          s0_rlast,
    output logic          s0_rvalid,
    input  logic          s0_rready,
    // source 1 AR
    input  logic [3:0]    s1_arid,
    input  logic [31:0]   s1_araddr,
    input  logic [7:0]    s1_arlen,
    input  logic [2:0]    s1_arsize,
    input  logic [1:0]    s1_arburst,
    input  logic          s1_aruser,
    input  logic          s1_arvalid,
    output logic          s1_arready,
    // source 1 R
    output logic [3:0]    s1_rid,
    output logic [31:0]   s1_rdata,
    output logic [1:0]    s1_rresp,
    output logic          s1_rlast,
    output logic          s1_rvalid,
    input  logic          s1_rready,
    // AXI master AR
    output logic [3:0]    m_arid,
    output logic [31:0]   m_araddr,
    output logic [7:0]    m_arlen,
    output logic [2:0]    m_arsize,
    output logic [1:0]    m_arburst,
    output logic          m_aruser,
    output logic          m_arvalid,
    input  logic          m_arready,
    // AXI master R
    input  logic [3:0]    m_rid,
    input  logic [31:0]   m_rdata,
    input  logic [1:0]    m_rresp,
    input  logic          m_rlast,
    input  logic          m_rvalid,
    output logic          m_rready,
    // status
    output logic [CW-1:0] s0_outstanding,
    output logic [CW-1:0] s1_outstanding,
    output logic          err_orphan_r
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    state_t        state_r;
    state_t        state_nxt_s;
    logic          rr_r;
    logic          elig0_s;
    logic          elig1_s;
    logic          grant0_s;
    logic          grant1_s;
    logic [3:0]    arid_r;
    logic [31:0]   araddr_r;
    logic [7:0]    arlen_r;
    logic [2:0]    arsize_r;
    logic [1:0]    arburst_r;
    logic          aruser_r;
    logic [CW-1:0] cnt0_r;
    logic [CW-1:0] cnt1_r;
    logic          r_hs_s;
    logic          r_sel_s;
    logic          rdone0_s;
    logic          rdone1_s;
    logic          orphan_s;

    // Next outstanding count; a completion against an empty counter is an
    // orphan and must not underflow, so it is ignored here.
    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic inc,
                                                 input logic dec);
        logic dec_eff;
        dec_eff = dec & (cnt != {CW{1'b0}});
        if (inc && !dec_eff) begin
            next_count = cnt + CW'(1);
        end else if (dec_eff && !inc) begin
            next_count = cnt - CW'(1);
        end else begin
            next_count = cnt;
        end
    endfunction

    assign elig0_s = s0_arvalid & (cnt0_r != CNT_MAX);
    assign elig1_s = s1_arvalid & (cnt1_r != CNT_MAX);

    // Round-robin grant in IDLE and next-state selection.
    always_comb begin
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (elig0_s && elig1_s) begin
                    grant0_s = ~rr_r;
                    grant1_s = rr_r;
                end else begin
                    grant0_s = elig0_s;
                    grant1_s = elig1_s;
                end
                if (grant0_s || grant1_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (m_arready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, round-robin pointer and registered AR payload.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            rr_r      <= 1'b0;
            arid_r    <= 4'h0;
            araddr_r  <= 32'h0000_0000;
            arlen_r   <= 8'h00;
            arsize_r  <= 3'b000;
            arburst_r <= 2'b00;
            aruser_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant1_s) begin
                rr_r      <= 1'b0;
                arid_r    <= {1'b1, s1_arid[2:0]};
                araddr_r  <= s1_araddr;
                arlen_r   <= s1_arlen;
                arsize_r  <= s1_arsize;
                arburst_r <= s1_arburst;
                aruser_r  <= s1_aruser;
            end else if (grant0_s) begin
                rr_r      <= 1'b1;
                arid_r    <= {1'b0, s0_arid[2:0]};
                araddr_r  <= s0_araddr;
                arlen_r   <= s0_arlen;
                arsize_r  <= s0_arsize;
                arburst_r <= s0_arburst;
                aruser_r  <= s0_aruser;
            end else begin
                rr_r <= rr_r;
            end
        end
    end

    assign s0_arready = grant0_s;
    assign s1_arready = grant1_s;
    assign m_arvalid  = (state_r == ST_HOLD);
    assign m_arid     = arid_r;
    assign m_araddr   = araddr_r;
    assign m_arlen    = arlen_r;
    assign m_arsize   = arsize_r;
    assign m_arburst  = arburst_r;
    assign m_aruser   = aruser_r;

    // R routing: pure steering by rid[3], nothing stored.
    assign r_sel_s   = m_rid[3];
    assign s0_rvalid = m_rvalid & ~r_sel_s;
    assign s1_rvalid = m_rvalid & r_sel_s;
    assign m_rready  = r_sel_s ? s1_rready : s0_rready;
    assign s0_rid    = {1'b0, m_rid[2:0]};
    assign s1_rid    = {1'b0, m_rid[2:0]};
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;

    assign r_hs_s   = m_rvalid & m_rready;
    assign rdone0_s = r_hs_s & m_rlast & ~r_sel_s;
    assign rdone1_s = r_hs_s & m_rlast & r_sel_s;
    assign orphan_s = r_hs_s & (r_sel_s ? (cnt1_r == {CW{1'b0}})
                                        : (cnt0_r == {CW{1'b0}}));

    // Outstanding burst counters and sticky orphan-beat flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt0_r       <= {CW{1'b0}};
            cnt1_r       <= {CW{1'b0}};
            err_orphan_r <= 1'b0;
        end else begin
            cnt0_r       <= next_count(cnt0_r, grant0_s, rdone0_s);
            cnt1_r       <= next_count(cnt1_r, grant1_s, rdone1_s);
            err_orphan_r <= err_orphan_r | orphan_s;
        end
    end

    assign s0_outstanding = cnt0_r;
    assign s1_outstanding = cnt1_r;

endmodule

// File: tb/tb_fetch_axi_read_arbiter.sv
// Directed testbench for fetch_axi_read_arbiter (MAX_OUTSTANDING = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 time units after the rising edge.
module tb_fetch_axi_read_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  s0_arid, s1_arid;
    logic [31:0] s0_araddr, s1_araddr;
    logic [7:0]  s0_arlen, s1_arlen;
    logic [2:0]  s0_arsize, s1_arsize;
    logic [1:0]  s0_arburst, s1_arburst;
    logic        s0_aruser, s1_aruser;
    logic        s0_arvalid, s1_arvalid;
    logic        s0_arready, s1_arready;
    logic [3:0]  s0_rid, s1_rid;
    logic [31:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        s0_rlast, s1_rlast;
    logic        s0_rvalid, s1_rvalid;
    logic        s0_rready, s1_rready;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_aruser;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic [2:0]  s0_outstanding, s1_outstanding;
    logic        err_orphan_r;

    int n_vec;
    int n_err;

    fetch_axi_read_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .resetn(resetn),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_aruser(s0_aruser),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_aruser(s1_aruser),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_aruser(m_aruser),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s0_outstanding(s0_outstanding), .s1_outstanding(s1_outstanding),
        .err_orphan_r(err_orphan_r)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #2;
    endtask

    task automatic clear_inputs();
        s0_arid = 4'h0; s0_araddr = 32'h0; s0_arlen = 8'h0; s0_arsize = 3'h0;
        s0_arburst = 2'h0; s0_aruser = 1'b0; s0_arvalid = 1'b0; s0_rready = 1'b0;
        s1_arid = 4'h0; s1_araddr = 32'h0; s1_arlen = 8'h0; s1_arsize = 3'h0;
        s1_arburst = 2'h0; s1_aruser = 1'b0; s1_arvalid = 1'b0; s1_rready = 1'b0;
        m_arready = 1'b0; m_rid = 4'h0; m_rdata = 32'h0; m_rresp = 2'h0;
        m_rlast = 1'b0; m_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Issue one AR from a source and complete its HOLD phase immediately.
    task automatic ar_issue(input bit src, input logic [3:0] id);
        int n;
        logic g;
        if (src) begin s1_arid = id; s1_arvalid = 1'b1; end
        else     begin s0_arid = id; s0_arvalid = 1'b1; end
        sample();
        n = 0;
        g = src ? s1_arready : s0_arready;
        while (!g && n < 10) begin
            tick();
            sample();
            g = src ? s1_arready : s0_arready;
            n++;
        end
        check_val("ar_grant", {31'h0, g}, 32'h1);
        tick();
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        m_arready  = 1'b1;
        sample();
        check_val("ar_hold_valid", {31'h0, m_arvalid}, 32'h1);
        tick();
        m_arready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        do_reset();
        sample();
        check_val("rst_arvalid", {31'h0, m_arvalid}, 32'h0);
        check_val("rst_arid", {28'h0, m_arid}, 32'h0);
        check_val("rst_araddr", m_araddr, 32'h0);
        check_val("rst_cnt0", {29'h0, s0_outstanding}, 32'h0);
        check_val("rst_err", {31'h0, err_orphan_r}, 32'h0);
        check_val("rst_arready", {30'h0, s1_arready, s0_arready}, 32'h0);

        // 1: single source-0 burst of 8 beats
        tick();
        s0_arid = 4'h2; s0_araddr = 32'h1FC0_0000; s0_arlen = 8'd7;
        s0_arsize = 3'd2; s0_arburst = 2'd1; s0_arvalid = 1'b1;
        sample();
        check_val("t1_grant", {30'h0, s1_arready, s0_arready}, 32'h1);
        check_val("t1_arvalid_T", {31'h0, m_arvalid}, 32'h0);
        tick();
        s0_arvalid = 1'b0;
        sample();
        check_val("t1_arvalid_T1", {31'h0, m_arvalid}, 32'h1);
        check_val("t1_arid", {28'h0, m_arid}, 32'h2);
        check_val("t1_araddr", m_araddr, 32'h1FC0_0000);
        check_val("t1_arlen", {24'h0, m_arlen}, 32'h7);
        check_val("t1_cnt_up", {29'h0, s0_outstanding}, 32'h1);
        check_val("t1_hold_ready", {31'h0, s0_arready}, 32'h0);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        sample();
        check_val("t1_idle", {31'h0, m_arvalid}, 32'h0);
        s0_rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_rvalid = 1'b1; m_rid = 4'h2; m_rdata = 32'hA000_0000 + i;
            m_rlast = (i == 7);
            sample();
            check_val("t1_s0_rvalid", {31'h0, s0_rvalid}, 32'h1);
            check_val("t1_s1_rvalid", {31'h0, s1_rvalid}, 32'h0);
            check_val("t1_rdata", s0_rdata, 32'hA000_0000 + i);
            check_val("t1_rid", {28'h0, s0_rid}, 32'h2);
            check_val("t1_cnt_mid", {29'h0, s0_outstanding}, 32'h1);
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        sample();
        check_val("t1_cnt_down", {29'h0, s0_outstanding}, 32'h0);

        // 2: round-robin after reset
        do_reset();
        s0_arid = 4'h1; s1_arid = 4'h5; s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        sample();
        check_val("t2_first", {30'h0, s1_arready, s0_arready}, 32'h1);
        tick();
        s0_arvalid = 1'b0;
        sample();
        check_val("t2_hold_rdy", {30'h0, s1_arready, s0_arready}, 32'h0);
        check_val("t2_arid0", {28'h0, m_arid}, 32'h1);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        sample();
        check_val("t2_second", {30'h0, s1_arready, s0_arready}, 32'h2);
        tick();
        s1_arvalid = 1'b0;
        sample();
        check_val("t2_arid1", {28'h0, m_arid}, 32'hD);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        sample();
        check_val("t2_third", {30'h0, s1_arready, s0_arready}, 32'h1);

        // 3: outstanding limit on source 0
        do_reset();
        for (int i = 0; i < 4; i++) ar_issue(1'b0, 4'h0);
        sample();
        check_val("t3_cnt4", {29'h0, s0_outstanding}, 32'h4);
        s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        sample();
        check_val("t3_limit", {30'h0, s1_arready, s0_arready}, 32'h2);
        tick();
        s1_arvalid = 1'b0; m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 4'h0; m_rlast = 1'b1; s0_rready = 1'b1;
        sample();
        check_val("t3_still_blk", {31'h0, s0_arready}, 32'h0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        sample();
        check_val("t3_cnt3", {29'h0, s0_outstanding}, 32'h3);
        check_val("t3_resume", {31'h0, s0_arready}, 32'h1);
        tick();
        s0_arvalid = 1'b0;
        sample();
        check_val("t3_cnt_back4", {29'h0, s0_outstanding}, 32'h4);

        // 4: backpressure in HOLD keeps payload stable
        do_reset();
        s1_arid = 4'h3; s1_araddr = 32'hDEAD_BEE0; s1_arlen = 8'd3;
        s1_arsize = 3'd2; s1_arburst = 2'd1; s1_aruser = 1'b1; s1_arvalid = 1'b1;
        tick();
        s0_arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s1_araddr = 32'h5555_0000 + i; s1_arid = 4'h6;
            sample();
            check_val("t4_valid", {31'h0, m_arvalid}, 32'h1);
            check_val("t4_addr", m_araddr, 32'hDEAD_BEE0);
            check_val("t4_id_len", {20'h0, m_arid, m_arlen}, 32'hB03);
            check_val("t4_attr", {26'h0, m_arsize, m_arburst, m_aruser}, 32'h13);
            check_val("t4_rdy", {30'h0, s1_arready, s0_arready}, 32'h0);
            tick();
        end
        m_arready = 1'b1;
        sample();
        check_val("t4_hs_rdy", {30'h0, s1_arready, s0_arready}, 32'h0);
        tick();
        m_arready = 1'b0;
        sample();
        check_val("t4_idle", {31'h0, m_arvalid}, 32'h0);
        check_val("t4_idle_grant", {30'h0, s1_arready, s0_arready}, 32'h1);

        // 5: simultaneous accept and completion on source 1, then R backpressure
        do_reset();
        ar_issue(1'b1, 4'h1);
        ar_issue(1'b1, 4'h1);
        s1_arvalid = 1'b1;
        m_rvalid = 1'b1; m_rid = 4'h9; m_rlast = 1'b1; s1_rready = 1'b1;
        sample();
        check_val("t5_acc", {31'h0, s1_arready}, 32'h1);
        check_val("t5_rready", {31'h0, m_rready}, 32'h1);
        tick();
        s1_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b1;
        sample();
        check_val("t5_cnt2", {29'h0, s1_outstanding}, 32'h2);
        tick();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 4'h8; m_rlast = 1'b1; s1_rready = 1'b0;
        sample();
        check_val("t5_bp_rready", {31'h0, m_rready}, 32'h0);
        check_val("t5_bp_rvalid", {30'h0, s1_rvalid, s0_rvalid}, 32'h2);
        tick();
        sample();
        check_val("t5_held_cnt", {29'h0, s1_outstanding}, 32'h2);
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // 6: orphan beat on source 1
        do_reset();
        m_rvalid = 1'b1; m_rid = 4'h9; m_rlast = 1'b1; s1_rready = 1'b1;
        sample();
        check_val("t6_pre", {31'h0, err_orphan_r}, 32'h0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        sample();
        check_val("t6_err", {31'h0, err_orphan_r}, 32'h1);
        check_val("t6_cnt0", {29'h0, s1_outstanding}, 32'h0);
        tick();
        tick();
        sample();
        check_val("t6_sticky", {31'h0, err_orphan_r}, 32'h1);
        do_reset();
        sample();
        check_val("t6_cleared", {31'h0, err_orphan_r}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
